// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stall/flush sequencer.
// Holds the FSM state enum, the enable/flush control bundle, default timing
// constants and the RUN-state priority decode shared by RUN and MEM_WAIT release.
package pipe_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } pipe_state_t;

  // Field order is MSB first: five enables, then four flushes.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctl_t;

  localparam int unsigned INIT_CYCLES_DEF = 2;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned WAIT_W          = 16;
  localparam int unsigned INIT_W          = 4;

  // Canonical output patterns.
  localparam pipe_ctl_t CTL_INIT = 9'b00000_1111; // hold everything, bubble everything
  localparam pipe_ctl_t CTL_RUN  = 9'b11111_0000; // free-running pipeline
  localparam pipe_ctl_t CTL_WAIT = 9'b00001_0001; // freeze front, drain WB with bubbles
  localparam pipe_ctl_t CTL_ERR  = 9'b00000_0000; // dead pipeline until reset

  // RUN priority decode with the memory stall already excluded: a taken branch
  // kills IF/ID and ID/EX and overrides any load-use request; a load-use stall
  // holds PC and IF/ID and injects one bubble into ID/EX.
  function automatic pipe_ctl_t run_decode(input logic hzd_stall_n,
                                           input logic branch_taken);
    pipe_ctl_t c;
    c = CTL_RUN;
    if (branch_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (!hzd_stall_n) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: 16-bit saturating data-memory wait counter.
// load_i sets the count to 1 (first wait cycle), inc_i advances it, clr_i
// returns it to 0. timeout_o is high while the count equals MEM_TIMEOUT.
module pipe_wait_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then load, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = WAIT_W'(1);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Combines load-use, branch-taken and data-memory handshake requests into
// per-register enable/flush controls, primes the pipeline after reset and
// latches a sticky bus error when a memory access times out.
// Optional build macro PIPE_PERF_EN adds stall_cnt / flush_cnt counters.
//
// Handshake: dmem_req/dmem_ready form a valid/ready pair; an access completes
// in the cycle both are high. In RUN, ready without req is ignored; req
// without ready freezes the front of the pipe until ready arrives.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hzd_stall_n,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        bus_err,
  output pipe_state_t dbg_state
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);

  pipe_state_t       state_q, state_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic              bus_err_q, bus_err_d;
  pipe_ctl_t         ctl;
  logic              branch_flush;
  logic              t_load, t_inc, t_clr, t_timeout;

  pipe_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (t_load),
    .inc_i     (t_inc),
    .clr_i     (t_clr),
    .timeout_o (t_timeout)
  );

  // Output decode and next-state logic from current state plus live inputs.
  always_comb begin
    ctl          = CTL_INIT;
    state_d      = state_q;
    init_d       = init_q;
    bus_err_d    = bus_err_q;
    branch_flush = 1'b0;
    t_load       = 1'b0;
    t_inc        = 1'b0;
    t_clr        = 1'b0;
    case (state_q)
      INIT: begin
        ctl = CTL_INIT;
        if (init_q == INIT_LAST) begin
          state_d = RUN;
          init_d  = '0;
        end else begin
          init_d = init_q + INIT_W'(1);
        end
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          ctl     = CTL_WAIT;
          state_d = MEM_WAIT;
          t_load  = 1'b1;
        end else begin
          ctl          = run_decode(hzd_stall_n, branch_taken);
          branch_flush = branch_taken;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // Release cycle: replay whatever branch/load-use was frozen.
          ctl          = run_decode(hzd_stall_n, branch_taken);
          branch_flush = branch_taken;
          state_d      = RUN;
          t_clr        = 1'b1;
        end else begin
          ctl   = CTL_WAIT;
          t_inc = 1'b1;
          if (t_timeout) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        ctl = CTL_ERR;
      end
      default: begin
        ctl     = CTL_INIT;
        state_d = INIT;
      end
    endcase
  end

  // State, init counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      init_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_flush = ctl.memwb_flush;
  assign bus_err     = bus_err_q;
  assign dbg_state   = state_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             perf_active;

  assign perf_active = (state_q == RUN) || (state_q == MEM_WAIT);

  // Performance counters: stalled-PC cycles and applied branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (perf_active) begin
      if (!ctl.pc_en) stall_q <= stall_q + CNT_W'(1);
      if (branch_flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  // CNT_W only sizes the optional counters.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl (INIT_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hzd_stall_n = 1'b1;
  logic branch_taken = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ready = 1'b0;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic bus_err;
  logic [1:0] dbg_state;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];

  // Expected control patterns {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush}.
  localparam logic [8:0] E_INIT = 9'b00000_1111;
  localparam logic [8:0] E_RUN  = 9'b11111_0000;
  localparam logic [8:0] E_BR   = 9'b11111_1100;
  localparam logic [8:0] E_LU   = 9'b00111_0100;
  localparam logic [8:0] E_WAIT = 9'b00001_0001;
  localparam logic [8:0] E_ERR  = 9'b00000_0000;
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  typedef struct {
    logic       hzd_n;
    logic       br;
    logic       req;
    logic       rdy;
    logic [8:0] ctl;
  } vec_t;

  vec_t vecs[10];

  logic [8:0] ctl_act;
  assign ctl_act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipe_ctrl #(
    .INIT_CYCLES (2),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hzd_stall_n  (hzd_stall_n),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .bus_err      (bus_err),
    .dbg_state    (dbg_state)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // Scoreboard: compare live outputs with the oldest expected record.
  task automatic check(input string name);
    logic [11:0] exp;
    logic [11:0] act;
    act = {dbg_state, ctl_act, bus_err};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected record queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got state=%0d ctl=%b bus_err=%b, expected state=%0d ctl=%b bus_err=%b",
                 name, act[11:10], act[9:1], act[0], exp[11:10], exp[9:1], exp[0]);
      end
    end
  endtask

  // Driver: one clock cycle with given inputs, checked mid-cycle.
  task automatic cyc(input logic h, input logic b, input logic q, input logic r,
                     input logic [8:0] ctl, input logic [1:0] st, input logic be,
                     input string name);
    @(posedge clk);
    #1;
    hzd_stall_n  = h;
    branch_taken = b;
    dmem_req     = q;
    dmem_ready   = r;
    exp_q.push_back({st, ctl, be});
    @(negedge clk);
    check(name);
`ifdef PIPE_PERF_EN
    n_tests++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      n_fail++;
      $display("FAIL %s_perf: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
               name, stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
    if (st == S_RUN || st == S_WAIT) begin
      if (!ctl[8]) exp_stall++;
      if (ctl == E_BR) exp_flush++;
    end
`endif
  endtask

  // Driver: assert reset asynchronously mid-cycle and check INIT outputs at once.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back({S_INIT, E_INIT, 1'b0});
    check(name);
`ifdef PIPE_PERF_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
  endtask

  // Driver: release reset at a falling edge and walk through the INIT window.
  task automatic release_and_prime(input string tag);
    @(negedge clk);
    hzd_stall_n  = 1'b1;
    branch_taken = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
    rst_n        = 1'b1;
    cyc(1, 0, 0, 0, E_INIT, S_INIT, 0, {tag, "_init0"});
    cyc(1, 0, 0, 0, E_INIT, S_INIT, 0, {tag, "_init1"});
    cyc(1, 0, 0, 0, E_RUN,  S_RUN,  0, {tag, "_run_first"});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, E_RUN};  // idle
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, E_LU};   // load-use, one cycle
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, E_RUN};  // back to normal
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, E_BR};   // branch overrides load-use
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, E_BR};   // plain branch
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, E_RUN};  // zero-wait access
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, E_RUN};  // ready without req ignored
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, E_LU};   // zero-wait plus load-use
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, E_BR};   // zero-wait plus branch
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, E_RUN};  // idle

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back({S_INIT, E_INIT, 1'b0});
    check("reset_hold");
    release_and_prime("por");

    // Table-driven RUN decode
    foreach (vecs[i]) begin
      cyc(vecs[i].hzd_n, vecs[i].br, vecs[i].req, vecs[i].rdy,
          vecs[i].ctl, S_RUN, 1'b0, $sformatf("vec%0d", i));
    end

    // 3-cycle memory wait with branch held; branch applied on release
    cyc(1, 1, 1, 0, E_WAIT, S_RUN,  0, "mwb_enter");
    cyc(1, 1, 1, 0, E_WAIT, S_WAIT, 0, "mwb_w1");
    cyc(1, 1, 1, 0, E_WAIT, S_WAIT, 0, "mwb_w2");
    cyc(1, 1, 1, 1, E_BR,   S_WAIT, 0, "mwb_release");
    cyc(1, 0, 0, 0, E_RUN,  S_RUN,  0, "mwb_after");

    // 1-cycle memory wait with load-use frozen; stall applied on release
    cyc(0, 0, 1, 0, E_WAIT, S_RUN,  0, "mwl_enter");
    cyc(0, 0, 1, 1, E_LU,   S_WAIT, 0, "mwl_release");
    cyc(1, 0, 0, 0, E_RUN,  S_RUN,  0, "mwl_after");

    // Reset pulsed in the middle of a memory wait
    cyc(1, 0, 1, 0, E_WAIT, S_RUN,  0, "rmw_enter");
    cyc(1, 0, 1, 0, E_WAIT, S_WAIT, 0, "rmw_w1");
    async_reset("rmw_async_reset");
    release_and_prime("rmw");

    // Timeout: four wait cycles, then sticky ERR
    cyc(1, 0, 1, 0, E_WAIT, S_RUN,  0, "to_enter");
    cyc(1, 0, 1, 0, E_WAIT, S_WAIT, 0, "to_w1");
    cyc(1, 0, 1, 0, E_WAIT, S_WAIT, 0, "to_w2");
    cyc(1, 0, 1, 0, E_WAIT, S_WAIT, 0, "to_w3");
    cyc(1, 0, 1, 0, E_WAIT, S_WAIT, 0, "to_w4");
    cyc(1, 0, 1, 0, E_ERR,  S_ERR,  1, "to_err");
    cyc(1, 0, 0, 0, E_ERR,  S_ERR,  1, "to_err_idle");
    cyc(0, 1, 1, 1, E_ERR,  S_ERR,  1, "to_err_ignores_inputs");
    async_reset("to_async_reset");
    release_and_prime("post_err");

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
